// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: 16-master AHB arbiter, round-robin with lock override and split masking.
// Define AHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (master 0 highest).
module ahb_bus_arbiter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] HBUSREQx,
    input  logic [15:0] HLOCKx,
    input  logic [15:0] HSPLIT,
    input  logic        HREADY,
    output logic [15:0] HGRANTx,
    output logic [3:0]  HMASTER,
    output logic        HMASTLOCK
);
    logic [15:0] elig;
    logic        lock_hold;
    logic [3:0]  win;
    logic [3:0]  gidx;

    assign elig      = HBUSREQx & ~HSPLIT;
    assign lock_hold = HMASTLOCK & HLOCKx[HMASTER] & elig[HMASTER];

`ifdef AHB_ARB_FIXED_PRIO_EN
    // lowest eligible index wins unless the locked owner keeps the bus
    always_comb begin
        win = HMASTER;
        for (int i = 15; i >= 0; i--)
            if (elig[i]) win = 4'(i);
        if (lock_hold) win = HMASTER;
    end
`else
    logic       found;
    logic [3:0] idx;

    // search upward from the owner+1 with wrap, owner last; locked owner overrides
    always_comb begin
        win   = HMASTER;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 16; i++) begin
            idx = HMASTER + 4'(i) + 4'd1;
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        if (lock_hold) win = HMASTER;
    end
`endif

    // encode the one-hot grant into the handover master index
    always_comb begin
        gidx = '0;
        for (int i = 0; i < 16; i++)
            if (HGRANTx[i]) gidx = gidx | 4'(i);
    end

    // grant on HREADY-low cycles, hand ownership over on the next HREADY-high edge
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANTx   <= '0;
            HMASTER   <= '0;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            HGRANTx <= '0;
            if (|HGRANTx) begin
                HMASTER   <= gidx;
                HMASTLOCK <= HLOCKx[gidx];
            end
        end else begin
            HGRANTx <= (|elig) ? (16'd1 << win) : 16'd0;
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: scoreboard bench for ahb_bus_arbiter (directed vectors plus random grant properties).
module tb_ahb_bus_arbiter;
    logic        HCLK, HRESETn, HREADY, HMASTLOCK;
    logic [15:0] HBUSREQx, HLOCKx, HSPLIT, HGRANTx;
    logic [3:0]  HMASTER;

    typedef struct {
        logic [15:0] g;
        logic [3:0]  m;
        logic        l;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   fails   = 0;
    logic prev_rdy = 1'b0;
    logic prop_on  = 1'b0;

    ahb_bus_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
        .HGRANTx(HGRANTx), .HSPLIT(HSPLIT), .HREADY(HREADY),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // monitor: pops one expectation per cycle and checks grant properties
    always @(negedge HCLK) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (HGRANTx !== e.g || HMASTER !== e.m || HMASTLOCK !== e.l) begin
                fails++;
                $display("FAIL %s: got grant=%h master=%0d lock=%b, want grant=%h master=%0d lock=%b",
                         e.nm, HGRANTx, HMASTER, HMASTLOCK, e.g, e.m, e.l);
            end
        end
        if (prop_on) begin
            vectors++;
            if (!$onehot0(HGRANTx) || (prev_rdy && HGRANTx !== 16'd0)) begin
                fails++;
                $display("FAIL grant_prop: got grant=%h after ready=%b, want one-hot-or-zero and zero after ready",
                         HGRANTx, prev_rdy);
            end
        end
        prev_rdy = HREADY;
    end

    task automatic push(input logic [15:0] g, input logic [3:0] m, input logic l, input string nm);
        exp_t e;
        e.g = g; e.m = m; e.l = l; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic [15:0] rq, input logic [15:0] lk, input logic [15:0] sp,
                        input logic rdy, input logic [15:0] g, input logic [3:0] m,
                        input logic l, input string nm);
        HBUSREQx = rq; HLOCKx = lk; HSPLIT = sp; HREADY = rdy;
        @(posedge HCLK); #1;
        push(g, m, l, nm);
    endtask

    initial begin
        HRESETn = 1'b0; HBUSREQx = 16'hFFFF; HLOCKx = '0; HSPLIT = '0; HREADY = 1'b0;
        @(posedge HCLK); @(posedge HCLK); #1;
        push(16'h0, 4'd0, 1'b0, "rst_hold");
        @(posedge HCLK); #1;
        push(16'h0, 4'd0, 1'b0, "rst_release");
        HRESETn = 1'b1;
        prop_on = 1'b1;
`ifdef AHB_ARB_FIXED_PRIO_EN
        step(16'h8001, 16'h0, 16'h0, 1'b0, 16'h0001, 4'd0, 1'b0, "fp_grant1");
        step(16'h8001, 16'h0, 16'h0, 1'b0, 16'h0001, 4'd0, 1'b0, "fp_grant2");
        step(16'h8001, 16'h0, 16'h0, 1'b1, 16'h0000, 4'd0, 1'b0, "fp_hand");
        step(16'h8001, 16'h0, 16'h0, 1'b0, 16'h0001, 4'd0, 1'b0, "fp_grant3");
        step(16'h8000, 16'h0, 16'h0, 1'b0, 16'h8000, 4'd0, 1'b0, "fp_only15");
        step(16'h8001, 16'h0, 16'h0001, 1'b0, 16'h8000, 4'd0, 1'b0, "fp_split0");
`else
        step(16'h0006, 16'h0, 16'h0, 1'b0, 16'h0002, 4'd0, 1'b0, "rr_grant1");
        step(16'h0006, 16'h0, 16'h0, 1'b1, 16'h0000, 4'd1, 1'b0, "rr_hand1");
        step(16'h0006, 16'h0, 16'h0, 1'b0, 16'h0004, 4'd1, 1'b0, "rr_grant2");
        step(16'h0006, 16'h0, 16'h0, 1'b1, 16'h0000, 4'd2, 1'b0, "rr_hand2");
        step(16'h0006, 16'h0, 16'h0, 1'b0, 16'h0002, 4'd2, 1'b0, "rr_wrap");
        step(16'h0006, 16'h0, 16'h0, 1'b1, 16'h0000, 4'd1, 1'b0, "rr_hand3");
        step(16'h0008, 16'h0008, 16'h0, 1'b0, 16'h0008, 4'd1, 1'b0, "lk_grant3");
        step(16'h0008, 16'h0008, 16'h0, 1'b1, 16'h0000, 4'd3, 1'b1, "lk_hand3");
        step(16'h0009, 16'h0008, 16'h0, 1'b0, 16'h0008, 4'd3, 1'b1, "lk_hold1");
        step(16'h0009, 16'h0008, 16'h0, 1'b0, 16'h0008, 4'd3, 1'b1, "lk_hold2");
        step(16'h0009, 16'h0000, 16'h0, 1'b1, 16'h0000, 4'd3, 1'b0, "lk_drop");
        step(16'h0009, 16'h0000, 16'h0, 1'b0, 16'h0001, 4'd3, 1'b0, "lk_after");
        step(16'h0030, 16'h0000, 16'h0010, 1'b0, 16'h0020, 4'd3, 1'b0, "sp_one");
        step(16'h0030, 16'h0000, 16'h0030, 1'b0, 16'h0000, 4'd3, 1'b0, "sp_all");
        step(16'h0030, 16'h0000, 16'h0030, 1'b1, 16'h0000, 4'd3, 1'b0, "idle_hold");
`endif
        @(negedge HCLK); #1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge HCLK); #1;
            HBUSREQx = 16'($urandom);
            HLOCKx   = 16'($urandom);
            HSPLIT   = 16'($urandom) & 16'($urandom);
            HREADY   = 1'($urandom_range(0, 1));
        end
        @(negedge HCLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
